// File: rtl/mem_arbiter.sv
// Byte-serial RAM port arbiter: ROB stores take the port first, then
// load-buffer loads, then instruction fetch. Each 1/2/4-byte access is
// split into byte beats and finishes with one done pulse to its owner.
module mem_arbiter #(
    parameter int unsigned AddressWidth = 32,
    parameter int unsigned IDWidth      = 32,
    parameter logic [1:0]  IO_HI        = 2'b11
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    flush_in,
    input  logic                    rob_mem_en_in,
    input  logic [AddressWidth-1:0] rob_mem_addr_in,
    input  logic [2:0]              rob_mem_width_in,
    input  logic [IDWidth-1:0]      rob_mem_data_in,
    output logic                    mem_rob_done_out,
    input  logic                    lb_mem_en_in,
    input  logic [AddressWidth-1:0] lb_mem_addr_in,
    input  logic [2:0]              lb_mem_width_in,
    input  logic                    lb_mem_signed_in,
    output logic                    mem_lb_done_out,
    output logic [IDWidth-1:0]      mem_lb_data_out,
    input  logic                    if_mem_en_in,
    input  logic [AddressWidth-1:0] if_mem_addr_in,
    output logic                    mem_if_done_out,
    output logic [IDWidth-1:0]      mem_if_inst_out,
    input  logic [7:0]              mem_din_in,
    input  logic                    io_buffer_full_in,
    output logic [7:0]              mem_dout_out,
    output logic [AddressWidth-1:0] mem_a_out,
    output logic                    mem_wr_out
);

    localparam int unsigned CntWidth = 3;

    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DONE} state_e;
    typedef enum logic [1:0] {OWN_ROB, OWN_LB, OWN_IF} owner_e;

    // Width code to byte count; unknown codes are full words.
    function automatic logic [CntWidth-1:0] width_bytes(input logic [2:0] code);
        case (code)
            3'b001:  return CntWidth'(1);
            3'b010:  return CntWidth'(2);
            default: return CntWidth'(4);
        endcase
    endfunction

    // Little-endian byte select from a data word.
    function automatic logic [7:0] word_byte(input logic [IDWidth-1:0] w, input logic [1:0] idx);
        case (idx)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

    state_e                  state_q, state_d;
    owner_e                  owner_q, owner_d;
    logic [CntWidth-1:0]     k_q, k_d;
    logic [CntWidth-1:0]     nbytes_q, nbytes_d;
    logic [AddressWidth-1:0] base_q, base_d;
    logic [IDWidth-1:0]      wdata_q, wdata_d;
    logic                    sgn_q, sgn_d;
    logic [IDWidth-1:0]      rbuf_q, rbuf_d;

    logic                    wr_q, wr_d;
    logic [AddressWidth-1:0] a_q, a_d;
    logic [7:0]              dout_q, dout_d;
    logic                    rob_done_q, rob_done_d;
    logic                    lb_done_q, lb_done_d;
    logic                    if_done_q, if_done_d;
    logic [IDWidth-1:0]      lb_data_q, lb_data_d;
    logic [IDWidth-1:0]      inst_q, inst_d;

    logic                    gnt_rob, gnt_lb, gnt_if;
    logic                    gnt_io_blk, wr_blk, last_beat;
    logic [IDWidth-1:0]      rd_word, ext_word;

    // Fixed-priority grant from IDLE; a flush only blocks speculative reads.
    always_comb begin
        gnt_rob = 1'b0;
        gnt_lb  = 1'b0;
        gnt_if  = 1'b0;
        if (state_q == ST_IDLE) begin
            gnt_rob = rob_mem_en_in;
            gnt_lb  = !rob_mem_en_in && lb_mem_en_in && !flush_in;
            gnt_if  = !rob_mem_en_in && !lb_mem_en_in && if_mem_en_in && !flush_in;
        end
    end

    // IO back-pressure and beat bookkeeping shared by both FSM processes.
    always_comb begin
        gnt_io_blk = (rob_mem_addr_in[17:16] == IO_HI) && io_buffer_full_in;
        wr_blk     = (base_q[17:16] == IO_HI) && io_buffer_full_in;
        last_beat  = (k_q == nbytes_q);
    end

    // Read word with the byte arriving this cycle merged in (byte k-1).
    always_comb begin
        rd_word = rbuf_q;
        case (k_q)
            3'd1:    rd_word[7:0]   = mem_din_in;
            3'd2:    rd_word[15:8]  = mem_din_in;
            3'd3:    rd_word[23:16] = mem_din_in;
            3'd4:    rd_word[31:24] = mem_din_in;
            default: rd_word = rbuf_q;
        endcase
    end

    // Sign or zero extension of narrow loads.
    always_comb begin
        case (nbytes_q)
            3'd1:    ext_word = sgn_q ? {{24{rd_word[7]}}, rd_word[7:0]}
                                      : {24'd0, rd_word[7:0]};
            3'd2:    ext_word = sgn_q ? {{16{rd_word[15]}}, rd_word[15:0]}
                                      : {16'd0, rd_word[15:0]};
            default: ext_word = rd_word;
        endcase
    end

    // State and output registers; rdy_in low freezes everything.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_ROB;
            k_q        <= '0;
            nbytes_q   <= '0;
            base_q     <= '0;
            wdata_q    <= '0;
            sgn_q      <= 1'b0;
            rbuf_q     <= '0;
            wr_q       <= 1'b0;
            a_q        <= '0;
            dout_q     <= '0;
            rob_done_q <= 1'b0;
            lb_done_q  <= 1'b0;
            if_done_q  <= 1'b0;
            lb_data_q  <= '0;
            inst_q     <= '0;
        end else if (rdy_in) begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            k_q        <= k_d;
            nbytes_q   <= nbytes_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            sgn_q      <= sgn_d;
            rbuf_q     <= rbuf_d;
            wr_q       <= wr_d;
            a_q        <= a_d;
            dout_q     <= dout_d;
            rob_done_q <= rob_done_d;
            lb_done_q  <= lb_done_d;
            if_done_q  <= if_done_d;
            lb_data_q  <= lb_data_d;
            inst_q     <= inst_d;
        end
    end

    // Next state, beat counter and latched request.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        k_d      = k_q;
        nbytes_d = nbytes_q;
        base_d   = base_q;
        wdata_d  = wdata_q;
        sgn_d    = sgn_q;
        rbuf_d   = rbuf_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_rob) begin
                    state_d  = ST_WRITE;
                    owner_d  = OWN_ROB;
                    base_d   = rob_mem_addr_in;
                    nbytes_d = width_bytes(rob_mem_width_in);
                    wdata_d  = rob_mem_data_in;
                    sgn_d    = 1'b0;
                    k_d      = gnt_io_blk ? CntWidth'(0) : CntWidth'(1);
                end else if (gnt_lb) begin
                    state_d  = ST_READ;
                    owner_d  = OWN_LB;
                    base_d   = lb_mem_addr_in;
                    nbytes_d = width_bytes(lb_mem_width_in);
                    sgn_d    = lb_mem_signed_in;
                    k_d      = '0;
                    rbuf_d   = '0;
                end else if (gnt_if) begin
                    state_d  = ST_READ;
                    owner_d  = OWN_IF;
                    base_d   = if_mem_addr_in;
                    nbytes_d = CntWidth'(4);
                    sgn_d    = 1'b0;
                    k_d      = '0;
                    rbuf_d   = '0;
                end
            end
            ST_WRITE: begin
                if (last_beat) begin
                    state_d = ST_DONE;
                end else if (!wr_blk) begin
                    k_d = k_q + CntWidth'(1);
                end
            end
            ST_READ: begin
                if (flush_in) begin
                    state_d = ST_IDLE;
                end else begin
                    rbuf_d = rd_word;
                    if (last_beat) begin
                        state_d = ST_DONE;
                    end else begin
                        k_d = k_q + CntWidth'(1);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered port outputs.
    always_comb begin
        wr_d       = 1'b0;
        a_d        = a_q;
        dout_d     = dout_q;
        rob_done_d = 1'b0;
        lb_done_d  = 1'b0;
        if_done_d  = 1'b0;
        lb_data_d  = lb_data_q;
        inst_d     = inst_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_rob) begin
                    a_d = rob_mem_addr_in;
                    if (!gnt_io_blk) begin
                        wr_d   = 1'b1;
                        dout_d = rob_mem_data_in[7:0];
                    end
                end else if (gnt_lb) begin
                    a_d = lb_mem_addr_in;
                end else if (gnt_if) begin
                    a_d = if_mem_addr_in;
                end
            end
            ST_WRITE: begin
                if (last_beat) begin
                    rob_done_d = 1'b1;
                end else if (!wr_blk) begin
                    wr_d   = 1'b1;
                    a_d    = base_q + AddressWidth'(k_q);
                    dout_d = word_byte(wdata_q, k_q[1:0]);
                end
            end
            ST_READ: begin
                if (!flush_in) begin
                    if ((k_q + CntWidth'(1)) < nbytes_q) begin
                        a_d = base_q + AddressWidth'(k_q + CntWidth'(1));
                    end
                    if (last_beat) begin
                        if (owner_q == OWN_LB) begin
                            lb_done_d = 1'b1;
                            lb_data_d = ext_word;
                        end else begin
                            if_done_d = 1'b1;
                            inst_d    = rd_word;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    assign mem_wr_out       = wr_q;
    assign mem_a_out        = a_q;
    assign mem_dout_out     = dout_q;
    assign mem_rob_done_out = rob_done_q;
    assign mem_lb_done_out  = lb_done_q;
    assign mem_if_done_out  = if_done_q;
    assign mem_lb_data_out  = lb_data_q;
    assign mem_if_inst_out  = inst_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte RAM model, shadow memory reference and
// transaction-level latency/data checks under directed and random traffic.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst, rdy, flush;
    logic        rob_en, lb_en, if_en, lb_sgn, io_full;
    logic [31:0] rob_addr, rob_data, lb_addr, if_addr;
    logic [2:0]  rob_w, lb_w;
    logic        rob_done, lb_done, if_done, mem_wr;
    logic [31:0] lb_data, inst, mem_a;
    logic [7:0]  mem_din, mem_dout;

    logic [7:0]  ram     [0:4095];
    logic [7:0]  ref_mem [0:4095];
    logic [39:0] beats[$];

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush_in(flush),
        .rob_mem_en_in(rob_en), .rob_mem_addr_in(rob_addr), .rob_mem_width_in(rob_w),
        .rob_mem_data_in(rob_data), .mem_rob_done_out(rob_done),
        .lb_mem_en_in(lb_en), .lb_mem_addr_in(lb_addr), .lb_mem_width_in(lb_w),
        .lb_mem_signed_in(lb_sgn), .mem_lb_done_out(lb_done), .mem_lb_data_out(lb_data),
        .if_mem_en_in(if_en), .if_mem_addr_in(if_addr), .mem_if_done_out(if_done),
        .mem_if_inst_out(inst), .mem_din_in(mem_din), .io_buffer_full_in(io_full),
        .mem_dout_out(mem_dout), .mem_a_out(mem_a), .mem_wr_out(mem_wr)
    );

    always #5 clk = ~clk;

    // Byte RAM with one-cycle read latency; stalls along with the rest of the system.
    always @(posedge clk) begin
        if (rdy) begin
            mem_din <= ram[mem_a[11:0]];
            if (mem_wr) begin
                ram[mem_a[11:0]] = mem_dout;
                beats.push_back({mem_a, mem_dout});
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int nbytes_of(input int op, input logic [2:0] code);
        if (op == 2) return 4;
        if (code == 3'b001) return 1;
        if (code == 3'b010) return 2;
        return 4;
    endfunction

    function automatic void ref_store(input logic [31:0] addr, input int nb, input logic [31:0] data);
        for (int i = 0; i < nb; i++) begin
            logic [31:0] ba = addr + 32'(i);
            ref_mem[ba[11:0]] = 8'(data >> (8 * i));
        end
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] addr, input int nb, input logic sgn);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < nb; i++) begin
            logic [31:0] ba = addr + 32'(i);
            v = v | (32'(ref_mem[ba[11:0]]) << (8 * i));
        end
        if (sgn && nb < 4 && v[8 * nb - 1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
        return v;
    endfunction

    task automatic check_beats(input logic [31:0] addr, input int nb, input logic [31:0] data);
        check_eq("beat_count", 64'(beats.size()), 64'(nb));
        for (int i = 0; i < nb && i < beats.size(); i++) begin
            logic [31:0] ba = addr + 32'(i);
            logic [7:0]  bd = 8'(data >> (8 * i));
            check_eq("beat", 64'(beats[i]), 64'({ba, bd}));
        end
    endtask

    // One request from the given requester; returns cycles from grant edge to done (-1: none).
    task automatic txn(input int op, input logic [31:0] addr, input logic [2:0] wcode,
                       input logic [31:0] data, input logic sgn, input int flush_at,
                       input int stall_at, input int full_until, input int max_cyc,
                       output int lat, output logic [31:0] rdata, output int first_wr);
        logic [31:0] a_snap = '0;
        logic [31:0] a_stall = '0;
        @(negedge clk);
        beats.delete();
        lat = -1; first_wr = -1; rdata = '0;
        case (op)
            0: begin rob_addr = addr; rob_w = wcode; rob_data = data; rob_en = 1'b1; end
            1: begin lb_addr = addr; lb_w = wcode; lb_sgn = sgn; lb_en = 1'b1; end
            default: begin if_addr = addr; if_en = 1'b1; end
        endcase
        if (flush_at == 0) flush = 1'b1;
        if (full_until > 0) io_full = 1'b1;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            @(posedge clk); #1;
            if (flush_at >= 0 && cyc == flush_at + 1) flush = 1'b0;
            if (op != 0 && flush_at > 0 && cyc == flush_at + 1)
                check_eq("flush_a_hold", 64'(mem_a), 64'(a_snap));
            if (flush_at > 0 && cyc == flush_at) begin
                flush = 1'b1;
                a_snap = mem_a;
                if (op != 0) begin lb_en = 1'b0; if_en = 1'b0; end
            end
            if (stall_at > 0 && cyc == stall_at + 3) begin
                check_eq("stall_a_frozen", 64'(mem_a), 64'(a_stall));
                rdy = 1'b1;
            end
            if (stall_at > 0 && cyc == stall_at) begin rdy = 1'b0; a_stall = mem_a; end
            if (full_until > 0 && cyc == full_until) io_full = 1'b0;
            if (mem_wr && first_wr < 0) first_wr = cyc;
            if ((op == 0 && rob_done) || (op == 1 && lb_done) || (op == 2 && if_done)) begin
                lat = cyc;
                rdata = (op == 1) ? lb_data : inst;
                check_eq("other_done",
                         64'((op == 0) ? {lb_done, if_done} : (op == 1) ? {rob_done, if_done} : {rob_done, lb_done}),
                         64'(0));
                rob_en = 1'b0; lb_en = 1'b0; if_en = 1'b0;
                @(posedge clk);
                break;
            end
        end
        rob_en = 1'b0; lb_en = 1'b0; if_en = 1'b0;
        flush = 1'b0; io_full = 1'b0; rdy = 1'b1;
    endtask

    initial begin
        int          lat, fw, t_rob, t_lb, t_if;
        logic [31:0] rd, d0, e_lb, e_if;
        logic [2:0]  codes [0:4];
        codes[0] = 3'b001; codes[1] = 3'b010; codes[2] = 3'b100; codes[3] = 3'b000; codes[4] = 3'b111;
        for (int i = 0; i < 4096; i++) begin
            logic [7:0] b = 8'($urandom);
            ram[i] = b;
            ref_mem[i] = b;
        end
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_full = 1'b0;
        rob_en = 1'b0; lb_en = 1'b0; if_en = 1'b0; lb_sgn = 1'b0;
        rob_addr = '0; rob_data = '0; rob_w = 3'b100; lb_addr = '0; lb_w = 3'b100; if_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_wr", 64'(mem_wr), 64'(0));
        check_eq("rst_a", 64'(mem_a), 64'(0));
        check_eq("rst_dout", 64'(mem_dout), 64'(0));
        check_eq("rst_dones", 64'({rob_done, lb_done, if_done}), 64'(0));
        check_eq("rst_lb_data", 64'(lb_data), 64'(0));
        check_eq("rst_inst", 64'(inst), 64'(0));
        @(negedge clk);
        rst = 1'b0;

        // Word store, then signed and unsigned byte loads of 0x80.
        txn(0, 32'h100, 3'b100, 32'hAABBCCDD, 1'b0, -1, 0, 0, 30, lat, rd, fw);
        check_eq("sw_lat", 64'(lat), 64'(5));
        check_beats(32'h100, 4, 32'hAABBCCDD);
        ref_store(32'h100, 4, 32'hAABBCCDD);
        ram[12'h020] = 8'h80; ref_mem[12'h020] = 8'h80;
        txn(1, 32'h20, 3'b001, '0, 1'b1, -1, 0, 0, 30, lat, rd, fw);
        check_eq("lb_lat", 64'(lat), 64'(3));
        check_eq("lb_data", 64'(rd), 64'(32'hFFFFFF80));
        txn(1, 32'h20, 3'b001, '0, 1'b0, -1, 0, 0, 30, lat, rd, fw);
        check_eq("lbu_data", 64'(rd), 64'(32'h00000080));

        // Simultaneous store, load and fetch: serviced in priority order.
        @(negedge clk);
        beats.delete();
        d0 = $urandom;
        rob_addr = 32'h200; rob_w = 3'b100; rob_data = d0; rob_en = 1'b1;
        lb_addr = 32'h202; lb_w = 3'b010; lb_sgn = 1'b1; lb_en = 1'b1;
        if_addr = 32'h200; if_en = 1'b1;
        ref_store(32'h200, 4, d0);
        e_lb = exp_read(32'h202, 2, 1'b1);
        e_if = exp_read(32'h200, 4, 1'b0);
        t_rob = -1; t_lb = -1; t_if = -1;
        for (int cyc = 1; cyc <= 40 && t_if < 0; cyc++) begin
            @(posedge clk); #1;
            if (rob_done) begin
                t_rob = cyc; rob_en = 1'b0;
                check_eq("prio_excl_rob", 64'({lb_done, if_done}), 64'(0));
            end
            if (lb_done) begin
                t_lb = cyc; lb_en = 1'b0;
                check_eq("prio_lb_data", 64'(lb_data), 64'(e_lb));
            end
            if (if_done) begin
                t_if = cyc; if_en = 1'b0;
                check_eq("prio_inst", 64'(inst), 64'(e_if));
            end
        end
        rob_en = 1'b0; lb_en = 1'b0; if_en = 1'b0;
        @(posedge clk);
        check_eq("prio_t_rob", 64'(t_rob), 64'(5));
        check_eq("prio_t_lb", 64'(t_lb), 64'(10));
        check_eq("prio_t_if", 64'(t_if), 64'(17));
        check_beats(32'h200, 4, d0);

        // Fetch flushed after its second byte: no done, port free right after.
        txn(2, 32'h300, 3'b100, '0, 1'b0, 4, 0, 0, 15, lat, rd, fw);
        check_eq("flush_if_nodone", 64'(lat), 64'(-1));
        check_eq("flush_if_nowr", 64'(beats.size()), 64'(0));
        txn(1, 32'h300, 3'b100, '0, 1'b0, -1, 0, 0, 30, lat, rd, fw);
        check_eq("post_flush_lat", 64'(lat), 64'(6));
        check_eq("post_flush_data", 64'(rd), 64'(exp_read(32'h300, 4, 1'b0)));

        // Store survives a flush mid-write.
        txn(0, 32'h310, 3'b100, 32'h12345678, 1'b0, 2, 0, 0, 30, lat, rd, fw);
        check_eq("flush_sw_lat", 64'(lat), 64'(5));
        check_beats(32'h310, 4, 32'h12345678);
        ref_store(32'h310, 4, 32'h12345678);

        // Flush in IDLE holds off a load by one cycle but not a store.
        txn(1, 32'h311, 3'b001, '0, 1'b1, 0, 0, 0, 30, lat, rd, fw);
        check_eq("idle_flush_lb_lat", 64'(lat), 64'(4));
        check_eq("idle_flush_lb_data", 64'(rd), 64'(exp_read(32'h311, 1, 1'b1)));
        txn(0, 32'h320, 3'b010, 32'h0000BEEF, 1'b0, 0, 0, 0, 30, lat, rd, fw);
        check_eq("idle_flush_sh_lat", 64'(lat), 64'(3));
        check_beats(32'h320, 2, 32'h0000BEEF);
        ref_store(32'h320, 2, 32'h0000BEEF);

        // IO store held back while the UART buffer is full.
        txn(0, 32'h30000, 3'b001, 32'h0000005A, 1'b0, -1, 0, 5, 30, lat, rd, fw);
        check_eq("io_first_wr", 64'(fw), 64'(6));
        check_eq("io_lat", 64'(lat), 64'(7));
        check_beats(32'h30000, 1, 32'h0000005A);
        ref_store(32'h30000, 1, 32'h0000005A);

        // Three-cycle global stall mid-read: same data, three cycles later.
        txn(1, 32'h40, 3'b100, '0, 1'b0, -1, 0, 0, 30, lat, d0, fw);
        check_eq("nostall_lat", 64'(lat), 64'(6));
        check_eq("nostall_data", 64'(d0), 64'(exp_read(32'h40, 4, 1'b0)));
        txn(1, 32'h40, 3'b100, '0, 1'b0, -1, 2, 0, 30, lat, rd, fw);
        check_eq("stall_lat", 64'(lat), 64'(9));
        check_eq("stall_data", 64'(rd), 64'(d0));

        // Address wrap across the top of the address space.
        txn(0, 32'hFFFFFFFE, 3'b100, 32'hCAFEF00D, 1'b0, -1, 0, 0, 30, lat, rd, fw);
        check_beats(32'hFFFFFFFE, 4, 32'hCAFEF00D);
        ref_store(32'hFFFFFFFE, 4, 32'hCAFEF00D);
        txn(2, 32'hFFFFFFFF, 3'b100, '0, 1'b0, -1, 0, 0, 30, lat, rd, fw);
        check_eq("wrap_inst", 64'(rd), 64'(exp_read(32'hFFFFFFFF, 4, 1'b0)));

        // Random single transactions against the shadow memory.
        for (int n = 0; n < 30; n++) begin
            int          op  = int'($urandom_range(0, 2));
            logic [2:0]  wc  = codes[$urandom_range(0, 4)];
            logic [31:0] ad  = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                                           : 32'($urandom_range(0, 4095));
            logic [31:0] dat = $urandom;
            logic        sg  = 1'($urandom_range(0, 1));
            int          nb  = nbytes_of(op, wc);
            logic [31:0] ex  = '0;
            if (op != 0) ex = exp_read(ad, nb, (op == 1) && sg);
            txn(op, ad, wc, dat, sg, -1, 0, 0, 30, lat, rd, fw);
            check_eq("rnd_lat", 64'(lat), 64'((op == 0) ? nb + 1 : nb + 2));
            if (op == 0) begin
                check_beats(ad, nb, dat);
                ref_store(ad, nb, dat);
            end else begin
                check_eq("rnd_data", 64'(rd), 64'(ex));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
